// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder
//   I2C target that acknowledges its own 7-bit address, collects bytes
//   written by the controller, and returns bytes to the controller on a read.
//   It stretches SCL while it waits for the local side to supply a read byte.
//   All bus decoding uses synchronized copies of SCL/SDA, which adds three
//   cycles of input latency.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_n_i     asynchronous active-low reset
//   scl_i       raw SCL line level
//   sda_i       raw SDA line level
//   scl_oe_o    1 = pull SCL low (clock stretch)
//   sda_oe_o    1 = pull SDA low, 0 = release
//   rx_data_o   last byte written by the controller
//   rx_valid_o  one-cycle strobe, rx_data_o holds a new byte
//   tx_req_o    level, a read byte is needed
//   tx_data_i   byte to return to the controller
//   tx_valid_i  tx_data_i valid; accepted only while tx_req_o = 1
//   busy_o      1 while addressed (address ACK through read ACK)
module i2c_slave_responder #(
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR     = 7'h22
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      scl_oe_o,
  output logic                      sda_oe_o,
  output logic [I2C_DATA_WIDTH-1:0] rx_data_o,
  output logic                      rx_valid_o,
  output logic                      tx_req_o,
  input  logic [I2C_DATA_WIDTH-1:0] tx_data_i,
  input  logic                      tx_valid_i,
  output logic                      busy_o
);

  localparam int                CNT_W    = $clog2(I2C_DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(I2C_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_WAIT, RD_DATA, RD_ACK
  } state_e;

  // Input synchronizers plus one delayed copy for edge detection
  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_dly_q, sda_dly_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_dly_q  <= scl_sync_q[1];
      sda_dly_q  <= sda_sync_q[1];
    end
  end

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  =  scl_s & ~scl_dly_q;
  assign scl_fall  = ~scl_s &  scl_dly_q;
  // SDA may only change while SCL is low, except for START/STOP
  assign start_det = scl_s & scl_dly_q &  sda_dly_q & ~sda_s;
  assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q &  sda_s;

  // Bus protocol FSM
  state_e                    state_q;
  logic [CNT_W-1:0]          bit_cnt_q;
  logic [I2C_DATA_WIDTH-2:0] shift_q;
  logic [I2C_DATA_WIDTH-1:0] tx_shift_q;
  logic                      rw_q;
  logic                      nack_q;
  logic                      sda_oe_q, scl_oe_q;
  logic [I2C_DATA_WIDTH-1:0] rx_data_q;
  logic                      rx_valid_q, tx_req_q, busy_q;

  // Byte as it stands once the bit currently on SDA is shifted in
  logic [I2C_DATA_WIDTH-1:0] byte_d;
  assign byte_d = {shift_q, sda_s};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      rw_q       <= 1'b0;
      nack_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (start_det) begin
        // START or repeated START abandons whatever was in progress
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_oe_q  <= 1'b0;
        scl_oe_q  <= 1'b0;
        tx_req_q  <= 1'b0;
        busy_q    <= 1'b0;
      end else if (stop_det) begin
        state_q  <= IDLE;
        sda_oe_q <= 1'b0;
        scl_oe_q <= 1'b0;
        tx_req_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shift_q   <= byte_d[I2C_DATA_WIDTH-2:0];
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == LAST_BIT) begin
                if (byte_d[I2C_DATA_WIDTH-1 -: I2C_ADDR_WIDTH] == SLAVE_ADDR) begin
                  state_q <= ADDR_ACK;
                  rw_q    <= byte_d[0];
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= IDLE;
                end
              end
            end
          end
          ADDR_ACK, WR_ACK: begin
            // sda_oe_q doubles as the phase flag: the first SCL fall starts
            // driving the ACK, the second ends the ACK bit.
            if (scl_fall) begin
              if (!sda_oe_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= '0;
                if (state_q == WR_ACK || !rw_q) begin
                  state_q <= WR_DATA;
                end else begin
                  state_q  <= RD_WAIT;
                  tx_req_q <= 1'b1;
                  scl_oe_q <= 1'b1;
                end
              end
            end
          end
          WR_DATA: begin
            if (scl_rise) begin
              shift_q   <= byte_d[I2C_DATA_WIDTH-2:0];
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == LAST_BIT) begin
                rx_data_q  <= byte_d;
                rx_valid_q <= 1'b1;
                state_q    <= WR_ACK;
              end
            end
          end
          RD_WAIT: begin
            // SCL is held low here, so driving the MSB now is safe
            if (tx_valid_i && tx_req_q) begin
              tx_shift_q <= tx_data_i;
              tx_req_q   <= 1'b0;
              scl_oe_q   <= 1'b0;
              sda_oe_q   <= ~tx_data_i[I2C_DATA_WIDTH-1];
              bit_cnt_q  <= '0;
              state_q    <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (bit_cnt_q == LAST_BIT) begin
                sda_oe_q <= 1'b0;
                state_q  <= RD_ACK;
              end else begin
                tx_shift_q <= tx_shift_q << 1;
                sda_oe_q   <= ~tx_shift_q[I2C_DATA_WIDTH-2];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              nack_q <= sda_s;
            end
            if (scl_fall) begin
              if (nack_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q  <= RD_WAIT;
                tx_req_q <= 1'b1;
                scl_oe_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign scl_oe_o   = scl_oe_q;
  assign sda_oe_o   = sda_oe_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_req_o   = tx_req_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Self-checking bench for i2c_slave_responder: an I2C controller model drives
// an open-drain bus, a local-side model answers read requests, and monitors
// collect received bytes, SDA-drive activity and SCL stretch length.
module tb_i2c_slave_responder;
  localparam int H = 10;  // cycles per SCL half period

  logic       clk = 1'b0;
  logic       rst_n_i;
  logic       master_scl, master_sda;
  logic       scl_line, sda_line;
  logic       scl_oe_o, sda_oe_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, tx_req_o, busy_o;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;

  assign scl_line = master_scl & ~scl_oe_o;
  assign sda_line = master_sda & ~sda_oe_o;

  i2c_slave_responder dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n_i),
    .scl_i      (scl_line),
    .sda_i      (sda_line),
    .scl_oe_o   (scl_oe_o),
    .sda_oe_o   (sda_oe_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .tx_req_o   (tx_req_o),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_log[$];
  logic [7:0] tx_q[$];
  int tx_delay = 0;
  int spur_cnt = 0;
  int cur_stretch = 0, max_stretch = 0;
  int oe_high_cycles = 0;
  int oe_viol = 0;
  logic prev_oe = 1'b0, prev_scl = 1'b1, prev_rst = 1'b0;

  // Bus monitors
  always @(negedge clk) begin
    if (rx_valid_o) rx_log.push_back(rx_data_o);
    if (sda_oe_o) oe_high_cycles++;
    if (scl_oe_o) begin
      cur_stretch++;
      if (cur_stretch > max_stretch) max_stretch = cur_stretch;
    end else begin
      cur_stretch = 0;
    end
    if (rst_n_i && prev_rst && scl_line && prev_scl && (sda_oe_o !== prev_oe)) oe_viol++;
    prev_oe  = sda_oe_o;
    prev_scl = scl_line;
    prev_rst = rst_n_i;
  end

  // Local-side model: answers tx_req_o after tx_delay cycles; may also emit
  // stray tx_valid_i pulses while no request is pending.
  initial begin
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_req_o && tx_q.size() > 0) begin
        repeat (tx_delay) @(negedge clk);
        tx_data_i  = tx_q.pop_front();
        tx_valid_i = 1'b1;
        @(negedge clk);
        tx_valid_i = 1'b0;
      end else if (!tx_req_o && spur_cnt > 0) begin
        tx_data_i  = 8'($urandom);
        tx_valid_i = 1'b1;
        @(negedge clk);
        tx_valid_i = 1'b0;
        spur_cnt--;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock with SCL starting and ending low; r is SDA mid-high.
  task automatic clock_bit(input logic b, output logic r);
    int cnt;
    master_sda = b;
    tick(H);
    master_scl = 1'b1;
    cnt = 0;
    while (scl_line !== 1'b1 && cnt < 2000) begin
      tick(1);
      cnt++;
    end
    if (cnt >= 2000) begin
      checks++; errors++;
      $display("FAIL scl_release_timeout waited %0d cycles, required < 2000", cnt);
    end
    tick(H / 2);
    r = sda_line;
    tick(H / 2);
    master_scl = 1'b0;
    tick(2);
  endtask

  task automatic bus_start();
    master_sda = 1'b1; tick(H);
    master_scl = 1'b1; tick(H);
    master_sda = 1'b0; tick(H);
    master_scl = 1'b0; tick(2);
  endtask

  task automatic bus_stop();
    master_sda = 1'b0; tick(H);
    master_scl = 1'b1; tick(H);
    master_sda = 1'b1; tick(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], r);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, r);
      b[i] = r;
    end
    clock_bit(nack, r);
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; master_scl = 1'b1; master_sda = 1'b1;
    tick(3);
    checks++; if (scl_oe_o !== 1'b0) begin errors++; $display("FAIL rst_scl_oe got %b want 0", scl_oe_o); end
    checks++; if (sda_oe_o !== 1'b0) begin errors++; $display("FAIL rst_sda_oe got %b want 0", sda_oe_o); end
    checks++; if (rx_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rx_valid got %b want 0", rx_valid_o); end
    checks++; if (tx_req_o !== 1'b0) begin errors++; $display("FAIL rst_tx_req got %b want 0", tx_req_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_o); end
    checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h want 00", rx_data_o); end
    rst_n_i = 1'b1;
    tick(5);
    checks++; if (busy_o !== 1'b0 || sda_oe_o !== 1'b0) begin errors++; $display("FAIL idle_after_rst busy=%b sda_oe=%b want 0 0", busy_o, sda_oe_o); end
  endtask

  task automatic test_write();
    logic ack;
    logic [7:0] exp[$];
    exp = '{8'hA5, 8'h3C};
    rx_log.delete();
    bus_start();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL wr_busy_in_addr got %b want 0", busy_o); end
    write_byte({7'h22, 1'b0}, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b want 0", ack); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL wr_busy got %b want 1", busy_o); end
    foreach (exp[i]) begin
      write_byte(exp[i], ack);
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_data_ack[%0d] got %b want 0", i, ack); end
    end
    bus_stop();
    tick(H);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL wr_busy_after_stop got %b want 0", busy_o); end
    checks++; if (rx_log.size() != exp.size()) begin errors++; $display("FAIL wr_rx_count got %0d want %0d", rx_log.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++; if (rx_log[i] !== exp[i]) begin errors++; $display("FAIL wr_rx[%0d] got %h want %h", i, rx_log[i], exp[i]); end
    end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] b;
    rx_log.delete();
    tx_q = '{8'h96, 8'h01};
    tx_delay = 20;
    max_stretch = 0;
    bus_start();
    write_byte({7'h22, 1'b1}, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b want 0", ack); end
    read_byte(1'b0, b);
    checks++; if (b !== 8'h96) begin errors++; $display("FAIL rd_byte0 got %h want 96", b); end
    read_byte(1'b1, b);
    checks++; if (b !== 8'h01) begin errors++; $display("FAIL rd_byte1 got %h want 01", b); end
    tick(H);
    checks++; if (busy_o !== 1'b0 || tx_req_o !== 1'b0) begin errors++; $display("FAIL rd_idle_after_nack busy=%b tx_req=%b want 0 0", busy_o, tx_req_o); end
    bus_stop();
    checks++; if (max_stretch < 20) begin errors++; $display("FAIL rd_stretch got %0d want >= 20", max_stretch); end
    checks++; if (rx_log.size() != 0) begin errors++; $display("FAIL rd_no_rx got %0d want 0", rx_log.size()); end
  endtask

  task automatic test_mismatch();
    logic ack;
    rx_log.delete();
    oe_high_cycles = 0;
    spur_cnt = 3;
    bus_start();
    write_byte({7'h23, 1'b0}, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_addr_nack got %b want 1", ack); end
    write_byte(8'hFF, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mm_data_nack got %b want 1", ack); end
    checks++; if (busy_o !== 1'b0 || tx_req_o !== 1'b0) begin errors++; $display("FAIL mm_busy busy=%b tx_req=%b want 0 0", busy_o, tx_req_o); end
    bus_stop();
    tick(2 * H);
    checks++; if (oe_high_cycles != 0) begin errors++; $display("FAIL mm_sda_driven got %0d cycles want 0", oe_high_cycles); end
    checks++; if (rx_log.size() != 0) begin errors++; $display("FAIL mm_rx got %0d want 0", rx_log.size()); end
    spur_cnt = 0;
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] b;
    rx_log.delete();
    tx_q = '{8'h55};
    tx_delay = $urandom_range(0, 15);
    bus_start();
    write_byte({7'h22, 1'b0}, ack);
    write_byte(8'h10, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL sr_wr_ack got %b want 0", ack); end
    bus_start();
    write_byte({7'h22, 1'b1}, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL sr_rd_addr_ack got %b want 0", ack); end
    read_byte(1'b1, b);
    checks++; if (b !== 8'h55) begin errors++; $display("FAIL sr_rd_byte got %h want 55", b); end
    bus_stop();
    checks++; if (rx_log.size() != 1 || rx_log[0] !== 8'h10) begin errors++; $display("FAIL sr_rx count=%0d first=%h want 1 10", rx_log.size(), (rx_log.size() > 0) ? rx_log[0] : 8'hxx); end
  endtask

  task automatic test_abort();
    logic ack, r;
    logic [7:0] d;
    rx_log.delete();
    bus_start();
    write_byte({7'h22, 1'b0}, ack);
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom), r);
    bus_stop();
    tick(H);
    checks++; if (rx_log.size() != 0 || busy_o !== 1'b0) begin errors++; $display("FAIL ab_stop rx=%0d busy=%b want 0 0", rx_log.size(), busy_o); end
    // Read of 0x00 keeps SDA pulled low throughout RD_DATA
    tx_q = '{8'h00};
    tx_delay = 3;
    bus_start();
    write_byte({7'h22, 1'b1}, ack);
    for (int i = 0; i < 3; i++) clock_bit(1'b1, r);
    tick(H / 2);
    checks++; if (sda_oe_o !== 1'b1) begin errors++; $display("FAIL ab_rd_driving got %b want 1", sda_oe_o); end
    rst_n_i = 1'b0;
    #1;
    checks++; if (sda_oe_o !== 1'b0 || scl_oe_o !== 1'b0) begin errors++; $display("FAIL ab_rst_release sda_oe=%b scl_oe=%b want 0 0", sda_oe_o, scl_oe_o); end
    tick(2);
    rst_n_i = 1'b1;
    tx_q.delete();
    tick(4);
    d = 8'($urandom);
    bus_start();
    write_byte({7'h22, 1'b0}, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ab_recover_ack got %b want 0", ack); end
    write_byte(d, ack);
    bus_stop();
    checks++; if (rx_log.size() != 1 || rx_log[0] !== d) begin errors++; $display("FAIL ab_recover_rx count=%0d want 1 byte %h", rx_log.size(), d); end
  endtask

  task automatic test_random_write();
    logic ack;
    logic [7:0] exp[$];
    int n;
    rx_log.delete();
    n = $urandom_range(3, 6);
    for (int i = 0; i < n; i++) exp.push_back(8'($urandom));
    bus_start();
    write_byte({7'h22, 1'b0}, ack);
    foreach (exp[i]) write_byte(exp[i], ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rw_last_ack got %b want 0", ack); end
    bus_stop();
    checks++; if (rx_log.size() != exp.size()) begin errors++; $display("FAIL rw_count got %0d want %0d", rx_log.size(), exp.size()); end
    else foreach (exp[i]) begin
      checks++; if (rx_log[i] !== exp[i]) begin errors++; $display("FAIL rw_rx[%0d] got %h want %h", i, rx_log[i], exp[i]); end
    end
  endtask

  task automatic test_random_read();
    logic ack;
    logic [7:0] b;
    logic [7:0] exp[$];
    int n;
    n = $urandom_range(2, 5);
    for (int i = 0; i < n; i++) exp.push_back(8'($urandom));
    tx_q = exp;
    tx_delay = $urandom_range(0, 30);
    bus_start();
    write_byte({7'h22, 1'b1}, ack);
    foreach (exp[i]) begin
      read_byte((i == n - 1), b);
      checks++; if (b !== exp[i]) begin errors++; $display("FAIL rr_byte[%0d] got %h want %h", i, b, exp[i]); end
    end
    tick(H);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rr_busy_after_nack got %b want 0", busy_o); end
    bus_stop();
  endtask

  initial begin
    master_scl = 1'b1;
    master_sda = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_mismatch();
    test_repeated_start();
    test_abort();
    for (int k = 0; k < 3; k++) begin
      test_random_write();
      test_random_read();
    end
    checks++; if (oe_viol != 0) begin errors++; $display("FAIL sda_change_while_scl_high got %0d want 0", oe_viol); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 SHALL have parameter I2C_ADDR_WIDTH, default 7, address width.
REQ-002 SHALL have parameter I2C_DATA_WIDTH, default 8, data byte width.
REQ-003 SHALL have parameter SLAVE_ADDR, default 7'h22, responder bus address.
REQ-004 SHALL have port clk_i  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port scl_i  input  1  raw SCL line level.
REQ-007 SHALL have port sda_i  input  1  raw SDA line level.
REQ-008 SHALL have port scl_oe_o  output  1  1 = pull SCL low (clock stretch).
REQ-009 SHALL have port sda_oe_o  output  1  1 = pull SDA low; 0 = release.
REQ-010 SHALL have port rx_data_o  output  I2C_DATA_WIDTH  last byte written by master.
REQ-011 SHALL have port rx_valid_o  output  1  one-cycle strobe, rx_data_o new.
REQ-012 SHALL have port tx_req_o  output  1  level; responder needs a read byte.
REQ-013 SHALL have port tx_data_i  input  I2C_DATA_WIDTH  byte to return to master.
REQ-014 SHALL have port tx_valid_i  input  1  tx_data_i valid; accepted when tx_req_o=1.
REQ-015 SHALL have port busy_o  output  1  1 from START to STOP while addressed.

Function
REQ-016 SHALL pass scl_i, sda_i through 2-flop synchronizers; all decode uses synchronized values plus one delayed copy for edge detection (3-cycle input latency).
REQ-017 SHALL detect START as SDA falling while SCL high, STOP as SDA rising while SCL high, in any state, including repeated START.
REQ-018 SHALL implement states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_WAIT, RD_DATA, RD_ACK.
REQ-019 START SHALL go to ADDR, clear bit counter, release sda_oe_o and scl_oe_o; STOP SHALL go to IDLE and release both.
REQ-020 SHALL sample SDA on each SCL rising edge in ADDR/WR_DATA, MSB first; 8 bits = address[6:0] then R/W.
REQ-021 Address match: SHALL enter ADDR_ACK; mismatch: SHALL go to IDLE, never drive SDA until next START.
REQ-022 SHALL change sda_oe_o only on the cycle after a synchronized SCL falling edge, never while SCL high.
REQ-023 ADDR_ACK: SHALL drive sda_oe_o=1 for one SCL high period; at following SCL fall go WR_DATA (R/W=0) or RD_WAIT (R/W=1).
REQ-024 WR_DATA: after 8th bit SHALL load rx_data_o, pulse rx_valid_o one cycle, enter WR_ACK (always ACK), then back to WR_DATA.
REQ-025 RD_WAIT: SHALL assert tx_req_o and scl_oe_o (stretch) until tx_valid_i=1; on that cycle latch tx_data_i, drop tx_req_o, release scl_oe_o, drive MSB, enter RD_DATA.
REQ-026 RD_DATA: SHALL set sda_oe_o = ~bit (0 bit pulls low), next bit after each SCL fall; after 8th SCL fall release SDA, enter RD_ACK.
REQ-027 RD_ACK: SHALL sample SDA at SCL rise; ACK(0) -> RD_WAIT at SCL fall; NACK(1) -> IDLE with SDA released.
REQ-028 tx_valid_i SHALL be ignored when tx_req_o=0; rx_valid_o SHALL not pulse on address bytes or partial bytes cut by START/STOP.
REQ-029 busy_o SHALL be 1 in ADDR_ACK..RD_ACK and 0 in IDLE and ADDR.

Reset
REQ-030 On rst_n_i=0 SHALL asynchronously enter IDLE; scl_oe_o, sda_oe_o, rx_valid_o, tx_req_o, busy_o = 0; rx_data_o = 0; synchronizers = 1 (lines idle high).
REQ-031 Reset mid-transfer SHALL release both lines immediately; after deassertion SHALL wait for a new START.

Verification
REQ-032 Write: START, addr 0x22 W, bytes 0xA5, 0x3C, STOP -> ACK on addr and both bytes; rx_valid_o twice with 0xA5 then 0x3C; busy_o 0 after STOP.
REQ-033 Read: START, addr 0x22 R; tb supplies 0x96 after 20-cycle delay, master ACKs, tb supplies 0x01, master NACKs, STOP -> SCL stretched 20+ cycles; bytes 0x96, 0x01 on SDA; IDLE after NACK.
REQ-034 Mismatch: START, addr 0x23 W, byte 0xFF -> sda_oe_o stays 0 throughout, no rx_valid_o, busy_o 0.
REQ-035 Repeated START: write 0x10 to 0x22, Sr, addr 0x22 R, tb supplies 0x55, NACK, STOP -> rx 0x10, then 0x55 read; no STOP needed between.
REQ-036 Abort: STOP after 4 data bits of write, and rst_n_i low during RD_DATA -> no rx_valid_o; lines released within 1 cycle of reset; next valid write succeeds.
